// File: rtl/bus_port_fifo_if.sv
// Bus-port endpoint signal bundle: device TX/RX side plus arbiter pndng/pop and push handshakes.
// The master drives the endpoint (device plus arbiter); the slave is the FIFO endpoint itself.
interface bus_port_fifo_if #(
   parameter int unsigned pckg_sz = 16
);
   logic               tx_wr;
   logic [pckg_sz-1:0] tx_data;
   logic               tx_full;
   logic               pndng;
   logic [pckg_sz-1:0] D_pop;
   logic               pop;
   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               rx_rd;
   logic [pckg_sz-1:0] rx_data;
   logic               rx_empty;
   logic [7:0]         drop_cnt;
   logic               err;

   modport master (
      output tx_wr, tx_data, pop, push, D_push, rx_rd,
      input  tx_full, pndng, D_pop, rx_data, rx_empty, drop_cnt, err
   );

   modport slave (
      input  tx_wr, tx_data, pop, push, D_push, rx_rd,
      output tx_full, pndng, D_pop, rx_data, rx_empty, drop_cnt, err
   );
endinterface

// File: rtl/bus_port_fifo.sv
// Per-device bus endpoint: TX FIFO feeding the arbiter, RX FIFO with destination-ID filtering.
// Both FIFOs are first-word fall-through register arrays with (log2(depth)+1)-bit pointers.
module bus_port_fifo #(
   parameter int unsigned pckg_sz   = 16,
   parameter int unsigned depth     = 8,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input logic            clk,
   input logic            reset,
   bus_port_fifo_if.slave bus
);

   localparam int unsigned AW = $clog2(depth);

   logic [pckg_sz-1:0] tx_mem_q [depth];
   logic [pckg_sz-1:0] rx_mem_q [depth];

   logic [AW:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [AW:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
   logic        err_q, err_d;

   logic       tx_full, tx_empty, rx_full, rx_empty;
   logic       tx_we, tx_re, rx_we, rx_re;
   logic       dst_match, drop;
   logic [7:0] dst;

   // Full: MSBs differ, index bits equal; empty: pointers identical.
   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                     (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
   assign rx_empty = (rx_wptr_q == rx_rptr_q);
   assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                     (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

   assign dst       = bus.D_push[pckg_sz-1 -: 8];
   assign dst_match = (dst == id) || (dst == broadcast);

   // Flags come from registered pointers, so a same-cycle pop never rescues a write into full.
   assign tx_we = bus.tx_wr && !tx_full;
   assign tx_re = bus.pop && !tx_empty;
   assign rx_we = bus.push && dst_match && !rx_full;
   assign rx_re = bus.rx_rd && !rx_empty;
   assign drop  = bus.push && (!dst_match || rx_full);

   always_comb begin
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      drop_cnt_d = drop_cnt_q;
      err_d      = err_q;
      if (tx_we) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_re) tx_rptr_d = tx_rptr_q + 1'b1;
      if (rx_we) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_re) rx_rptr_d = rx_rptr_q + 1'b1;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
      if ((bus.tx_wr && tx_full) || (bus.pop && tx_empty)) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wptr_q  <= '0;
         tx_rptr_q  <= '0;
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         drop_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         drop_cnt_q <= drop_cnt_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_we && !reset) tx_mem_q[tx_wptr_q[AW-1:0]] <= bus.tx_data;
      if (rx_we && !reset) rx_mem_q[rx_wptr_q[AW-1:0]] <= bus.D_push;
   end

   assign bus.tx_full  = tx_full;
   assign bus.pndng    = !tx_empty;
   assign bus.D_pop    = tx_mem_q[tx_rptr_q[AW-1:0]];
   assign bus.rx_empty = rx_empty;
   assign bus.rx_data  = rx_mem_q[rx_rptr_q[AW-1:0]];
   assign bus.drop_cnt = drop_cnt_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_bus_port_fifo.sv
// Randomized and directed bench for bus_port_fifo against a queue-based reference model.
module tb_bus_port_fifo;

   localparam int unsigned Depth  = 8;
   localparam int unsigned PckgSz = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   bus_port_fifo_if #(.pckg_sz(PckgSz)) bus ();

   bus_port_fifo #(
      .pckg_sz  (PckgSz),
      .depth    (Depth),
      .id       (8'h03),
      .broadcast(8'hFF)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: occupancy as queues, sticky error, saturating drop counter.
   logic [15:0] m_tx[$];
   logic [15:0] m_rx[$];
   logic        m_err  = 1'b0;
   int          m_drop = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic cyc(input logic wr, input logic [15:0] wd, input logic p, input logic ps,
                      input logic [15:0] pd, input logic rd, input logic rst);
      bit tx_was_full, tx_was_empty, rx_was_full, rx_was_empty, hit;
      @(negedge clk);
      reset       = rst;
      bus.tx_wr   = wr;
      bus.tx_data = wd;
      bus.pop     = p;
      bus.push    = ps;
      bus.D_push  = pd;
      bus.rx_rd   = rd;
      if (rst) begin
         m_tx.delete();
         m_rx.delete();
         m_err  = 1'b0;
         m_drop = 0;
      end else begin
         tx_was_full  = (m_tx.size() == Depth);
         tx_was_empty = (m_tx.size() == 0);
         rx_was_full  = (m_rx.size() == Depth);
         rx_was_empty = (m_rx.size() == 0);
         if (p) begin
            if (tx_was_empty) m_err = 1'b1;
            else void'(m_tx.pop_front());
         end
         if (wr) begin
            if (tx_was_full) m_err = 1'b1;
            else m_tx.push_back(wd);
         end
         if (rd && !rx_was_empty) void'(m_rx.pop_front());
         if (ps) begin
            hit = (pd[15:8] == 8'h03) || (pd[15:8] == 8'hFF);
            if (hit && !rx_was_full) m_rx.push_back(pd);
            else if (m_drop < 255) m_drop++;
         end
      end
      @(posedge clk);
      #1;
      check_eq("pndng", 32'(bus.pndng), 32'(m_tx.size() != 0));
      check_eq("tx_full", 32'(bus.tx_full), 32'(m_tx.size() == Depth));
      check_eq("rx_empty", 32'(bus.rx_empty), 32'(m_rx.size() == 0));
      check_eq("err", 32'(bus.err), 32'(m_err));
      check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
      if (m_tx.size() != 0) check_eq("D_pop", 32'(bus.D_pop), 32'(m_tx[0]));
      if (m_rx.size() != 0) check_eq("rx_data", 32'(bus.rx_data), 32'(m_rx[0]));
   endtask

   task automatic idle();
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.tx_wr   = 1'b0;
      bus.tx_data = '0;
      bus.pop     = 1'b0;
      bus.push    = 1'b0;
      bus.D_push  = '0;
      bus.rx_rd   = 1'b0;

      do_reset();
      do_reset();
      idle();

      // TX drain
      cyc(1'b1, 16'h0155, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0266, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0377, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      check_eq("drain_head", 32'(bus.D_pop), 32'h0155);
      for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      check_eq("drain_pndng", 32'(bus.pndng), 32'h0);
      check_eq("drain_err", 32'(bus.err), 32'h0);

      // TX overflow and pointer wrap
      for (int i = 0; i < 9; i++) cyc(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      check_eq("ovf_full", 32'(bus.tx_full), 32'h1);
      check_eq("ovf_err", 32'(bus.err), 32'h1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
         cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      end

      // RX filter
      do_reset();
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0311, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF22, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0533, 1'b0, 1'b0);
      check_eq("filt_head", 32'(bus.rx_data), 32'h0311);
      check_eq("filt_drop", 32'(bus.drop_cnt), 32'h1);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check_eq("filt_second", 32'(bus.rx_data), 32'hFF22);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

      // RX overflow, then push with read while full
      do_reset();
      for (int i = 0; i < 9; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'(16'h0340 + i), 1'b0, 1'b0);
      check_eq("rxovf_drop", 32'(bus.drop_cnt), 32'h1);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h03AA, 1'b1, 1'b0);
      check_eq("rxovf_drop2", 32'(bus.drop_cnt), 32'h2);
      check_eq("rxovf_head", 32'(bus.rx_data), 32'h0341);
      for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

      // Simultaneous write and pop at occupancy 4
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h3100 + i), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

      // Reset mid-traffic
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0501, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0301, 1'b0, 1'b0);
      cyc(1'b1, 16'h4444, 1'b0, 1'b1, 16'hFF02, 1'b0, 1'b0);
      cyc(1'b1, 16'h4555, 1'b1, 1'b1, 16'h0303, 1'b0, 1'b1);
      check_eq("rst_pndng", 32'(bus.pndng), 32'h0);
      check_eq("rst_rx_empty", 32'(bus.rx_empty), 32'h1);
      check_eq("rst_drop", 32'(bus.drop_cnt), 32'h0);
      check_eq("rst_err", 32'(bus.err), 32'h0);

      // Drop counter saturation
      for (int i = 0; i < 300; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'(16'h0700 + i), 1'b0, 1'b0);
      check_eq("sat_drop", 32'(bus.drop_cnt), 32'hFF);

      // Random traffic in phases with different fill pressure
      do_reset();
      for (int ph = 0; ph < 4; ph++) begin
         for (int i = 0; i < 500; i++) begin
            logic [7:0] d;
            logic       wr, p, ps, rd, rst;
            case ($urandom_range(3))
               0:       d = 8'h03;
               1:       d = 8'hFF;
               2:       d = 8'h05;
               default: d = 8'($urandom);
            endcase
            wr  = ($urandom_range(99) < ((ph == 1) ? 80 : (ph == 2) ? 20 : 50));
            p   = ($urandom_range(99) < ((ph == 1) ? 20 : (ph == 2) ? 80 : 50));
            ps  = ($urandom_range(99) < ((ph == 3) ? 90 : 60));
            rd  = ($urandom_range(99) < ((ph == 3) ? 15 : 45));
            rst = ($urandom_range(199) == 0);
            cyc(wr, 16'($urandom), p, ps, {d, 8'($urandom)}, rd, rst);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
